// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared geometry and FSM state type for the instruction cache
package icache_pkg;
   localparam int LINES = 32;
   localparam int WORDS = 4;
   localparam int TAG_W = 8;
   localparam int IDX_W = 5;
   localparam int OFF_W = 2;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
endpackage

// File: rtl/icache_tags.sv
// rtl/icache_tags.sv - tag/valid store: combinational lookup, write-on-fill, clear-all
module icache_tags
   import icache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] lkp_idx,
   input  logic [TAG_W-1:0] lkp_tag,
   output logic             hit,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             clr_all
);
   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q [LINES];

   always_comb begin
      valid_d = valid_q;
      if (clr_all) valid_d = '0;
      else if (wr_en) valid_d[wr_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) valid_q <= '0;
      else      valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en) tag_q[wr_idx] <= wr_tag;
   end

   assign hit = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache: zero-cycle hit, word-by-word line refill
module icache_ctrl
   import icache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [15:0] addr,
   input  logic        inval,
   output logic [15:0] instr,
   output logic        done,
   output logic        stall,
   output logic        err,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_rdata,
   input  logic        mem_rvalid
);
   state_t state_q, state_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [OFF_W-1:0] off_q, off_d, cnt_q, cnt_d;
   logic kill_q, kill_d;
   logic [15:0] data_q [LINES*WORDS];
   logic hit, fill_we, tag_we;
   logic [IDX_W+OFF_W-1:0] rd_sel;

   assign fill_we = (state_q == WAIT) && mem_rvalid;
   // kill_q marks a fill whose line was invalidated while in flight; it must not become valid
   assign tag_we = fill_we && (cnt_q == LAST_WORD) && !kill_q && !inval;

   icache_tags u_tags (
      .clk     (clk),
      .rst     (rst),
      .lkp_idx (addr[7:3]),
      .lkp_tag (addr[15:8]),
      .hit     (hit),
      .wr_en   (tag_we),
      .wr_idx  (idx_q),
      .wr_tag  (tag_q),
      .clr_all (inval)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         tag_q   <= '0;
         idx_q   <= '0;
         off_q   <= '0;
         cnt_q   <= '0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
         kill_q  <= kill_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) data_q[{idx_q, cnt_q}] <= mem_rdata;
   end

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      idx_d   = idx_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      kill_d  = kill_q | inval;
      unique case (state_q)
         IDLE: begin
            if (req && !addr[0] && !hit) begin
               tag_d   = addr[15:8];
               idx_d   = addr[7:3];
               off_d   = addr[2:1];
               cnt_d   = '0;
               kill_d  = 1'b0;
               state_d = REQ;
            end
         end
         REQ:  state_d = WAIT;
         WAIT: begin
            if (mem_rvalid) begin
               if (cnt_q == LAST_WORD) begin
                  state_d = RESP;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = REQ;
               end
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done     = 1'b0;
      stall    = 1'b0;
      err      = mem_rvalid && (state_q != WAIT);
      mem_rd   = 1'b0;
      mem_addr = '0;
      rd_sel   = {addr[7:3], addr[2:1]};
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (addr[0])  err   = 1'b1;
               else if (hit) done  = 1'b1;
               else          stall = 1'b1;
            end
         end
         REQ: begin
            stall    = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = {tag_q, idx_q, cnt_q, 1'b0};
         end
         WAIT: stall = 1'b1;
         RESP: begin
            done   = 1'b1;
            rd_sel = {idx_q, off_q};
         end
         default: ;
      endcase
      instr = done ? data_q[rd_sel] : 16'h0000;
   end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - randomized bench for icache_ctrl against a line-level cache model
module tb_icache_ctrl;
   logic        clk = 1'b0;
   logic        rst, req, inval, mem_rvalid;
   logic [15:0] addr, mem_rdata;
   logic [15:0] instr, mem_addr;
   logic        done, stall, err, mem_rd;

   icache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .addr       (addr),
      .inval      (inval),
      .instr      (instr),
      .done       (done),
      .stall      (stall),
      .err        (err),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      int          due;
   } pend_t;

   logic [15:0] mem [32768];
   pend_t       pend [$];
   bit   [31:0] vld;
   logic [7:0]  tg [32];
   int          cyc = 0;
   int          lat = 1;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Called right after the falling edge: presents any read response due this cycle.
   task automatic begin_cycle(input bit stray);
      @(negedge clk);
      cyc++;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mem[pend[0].a[15:1]];
         void'(pend.pop_front());
      end else if (stray) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 16'($urandom);
      end
   endtask

   task automatic settle();
      #1;
      if (mem_rd) pend.push_back('{a: mem_addr, due: cyc + lat});
   endtask

   task automatic idle(input bit stray);
      begin_cycle(stray);
      rst = 1'b1; req = 1'b0; inval = 1'b0;
      settle();
      chk("idle_err", err, mem_rvalid);
      chk("idle_done", done, 0);
      chk("idle_stall", stall, 0);
      chk("idle_mem_rd", mem_rd, 0);
      chk("idle_instr", instr, 0);
   endtask

   task automatic fetch(input logic [15:0] a, input int inv_in);
      int  idx;
      int  lat_exp;
      int  inv_at;
      int  nrd;
      bit  exp_hit;
      bit  got;
      idx     = int'(a[7:3]);
      inv_at  = inv_in;
      nrd     = 0;
      got     = 0;
      exp_hit = !a[0] && vld[idx] && (tg[idx] == a[15:8]);
      lat_exp = exp_hit ? 0 : 4 * (lat + 1) + 1;
      if (a[0] || inv_at >= (exp_hit ? 1 : lat_exp)) inv_at = -1;
      for (int k = 0; k <= lat_exp + 4 && !got; k++) begin
         begin_cycle(0);
         rst = 1'b1; req = 1'b1; addr = a; inval = (k == inv_at);
         settle();
         if (k == inv_at) vld = '0;
         chk("err", err, a[0]);
         if (a[0]) begin
            chk("odd_done", done, 0);
            chk("odd_mem_rd", mem_rd, 0);
            chk("odd_stall", stall, 0);
            got = 1;
         end else begin
            chk("done_stall_excl", done && stall, 0);
            if (mem_rd) begin
               chk("mem_addr", mem_addr, {a[15:3], 2'(nrd), 1'b0});
               nrd++;
            end
            if (done) begin
               chk("latency", k, lat_exp);
               chk("instr", instr, mem[a[15:1]]);
               got = 1;
            end else begin
               chk("stall", stall, 1);
            end
         end
      end
      if (!got) chk("timeout", 0, 1);
      if (!a[0]) begin
         chk("rd_count", nrd, exp_hit ? 0 : 4);
         if (!exp_hit && inv_at < 1) begin
            vld[idx] = 1'b1;
            tg[idx]  = a[15:8];
         end
      end
   endtask

   initial begin
      logic [15:0] ra;
      int          inv;
      rst = 1'b0; req = 1'b0; inval = 1'b0; addr = '0;
      mem_rvalid = 1'b0; mem_rdata = '0;
      vld = '0;
      for (int i = 0; i < 32; i++) tg[i] = '0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

      for (int i = 0; i < 2; i++) begin
         begin_cycle(0);
         rst = 1'b0;
         settle();
      end
      idle(0);
      idle(0);

      lat = 1;
      fetch(16'h0104, -1);
      fetch(16'h0106, -1);
      fetch(16'h0904, -1);
      fetch(16'h0104, -1);
      fetch(16'h2000, 2);
      fetch(16'h2000, -1);
      fetch(16'h0011, -1);
      idle(1);
      idle(0);

      // Reset in WAIT with a response still outstanding
      fetch(16'h0104, -1);
      lat = 2;
      begin_cycle(0); rst = 1'b1; req = 1'b1; addr = 16'h4000; inval = 1'b0; settle();
      chk("abort_miss_stall", stall, 1);
      begin_cycle(0); settle();
      chk("abort_mem_rd", mem_rd, 1);
      begin_cycle(0); rst = 1'b0; req = 1'b0; settle();
      chk("abort_wait_stall", stall, 1);
      vld = '0;
      begin_cycle(0); rst = 1'b1; settle();
      chk("rst_stall", stall, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("stray_after_rst", err, 1);
      idle(0);
      fetch(16'h0104, -1);

      for (int n = 0; n < 300; n++) begin
         lat = int'($urandom_range(1, 3));
         ra  = {8'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 2'($urandom), 1'b0};
         if ($urandom_range(0, 9) == 0) ra[0] = 1'b1;
         inv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12)) : -1;
         fetch(ra, inv);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 5) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
